led_effect_engine: RTL and testbench

LED_EFFECT_ENGINE -- requirements
Module: led_effect_engine

---
 rtl/led_effect_engine_pkg.sv | 23 ++
 rtl/led_effect_engine_tick_gen.sv | 51 +++++
 rtl/led_effect_engine.sv | 114 +++++++++++
 tb/tb_led_effect_engine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_effect_engine_pkg.sv
// Shared IO definitions for the LED driver and its effect engine: mode
// encodings, effect-config word field layout and small bit helpers.
package led_effect_engine_pkg;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_DIM    = 2'b11;

    localparam int unsigned CFG_MODE_LSB = 0;
    localparam int unsigned CFG_MODE_W   = 2;
    localparam int unsigned CFG_RATE_LSB = 2;
    localparam int unsigned CFG_RATE_W   = 4;
    localparam int unsigned CFG_DUTY_LSB = 6;
    localparam int unsigned CFG_DUTY_W   = 4;

    localparam int unsigned LED_W = 16;

    function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] value);
        return {value[LED_W-2:0], value[LED_W-1]};
    endfunction

endpackage

// File: rtl/led_effect_engine_tick_gen.sv
// Base-tick prescaler followed by a programmable step divider; emits a
// registered one-cycle step pulse every (rate+1) base ticks.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic [3:0] i_rate,
    output logic       o_step
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_cnt;
    logic          r_step;
    logic          w_tick;

    assign w_tick = (r_presc == PRESC_MAX);
    assign o_step = r_step;

    // Prescaler, step counter and step pulse; clear restarts timing and kills a coincident step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= {PW{1'b0}};
            r_cnt   <= 4'd0;
            r_step  <= 1'b0;
        end else if (i_clear) begin
            r_presc <= {PW{1'b0}};
            r_cnt   <= 4'd0;
            r_step  <= 1'b0;
        end else begin
            r_presc <= w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
            if (w_tick) begin
                if (r_cnt >= i_rate) begin
                    r_cnt  <= 4'd0;
                    r_step <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 4'd1;
                    r_step <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt;
                r_step <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_effect_engine.sv
// LED effect engine: applies pass/blink/scroll/dim effects to the LED
// driver's output word and drives the board LEDs from a register.
module led_effect_engine
    import led_effect_engine_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic        ledclk,
    input  logic        ledrst,
    input  logic [15:0] pattern,
    input  logic        cfgcs,
    input  logic        cfgwrite,
    input  logic [15:0] cfgdata,
    output logic [15:0] led_pin,
    output logic        step
);

    logic [1:0]  r_mode;
    logic [3:0]  r_rate;
    logic [3:0]  r_duty;
    logic        r_phase;
    logic [3:0]  r_pwm;
    logic [15:0] r_shadow;
    logic [15:0] r_prev_pattern;
    logic [15:0] r_led_pin;

    logic        w_cfg_wr;
    logic        w_step;
    logic [1:0]  w_mode_nxt;
    logic [3:0]  w_rate_nxt;
    logic [3:0]  w_duty_nxt;
    logic        w_phase_nxt;
    logic [3:0]  w_pwm_nxt;
    logic [15:0] w_shadow_nxt;
    logic [15:0] w_led_nxt;

    assign w_cfg_wr = cfgcs & cfgwrite;
    assign led_pin  = r_led_pin;
    assign step     = w_step;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (ledclk),
        .i_rst   (ledrst),
        .i_clear (w_cfg_wr),
        .i_rate  (r_rate),
        .o_step  (w_step)
    );

    // Next effect state; a config write wins over stepping and restarts all effect timing.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_rate_nxt   = r_rate;
        w_duty_nxt   = r_duty;
        w_phase_nxt  = r_phase;
        w_pwm_nxt    = r_pwm;
        w_shadow_nxt = r_shadow;
        if (w_cfg_wr) begin
            w_mode_nxt   = cfgdata[CFG_MODE_LSB +: CFG_MODE_W];
            w_rate_nxt   = cfgdata[CFG_RATE_LSB +: CFG_RATE_W];
            w_duty_nxt   = cfgdata[CFG_DUTY_LSB +: CFG_DUTY_W];
            w_phase_nxt  = 1'b0;
            w_pwm_nxt    = 4'd0;
            w_shadow_nxt = pattern;
        end else begin
            w_phase_nxt = r_phase ^ w_step;
            w_pwm_nxt   = r_pwm + 4'd1;
            if ((r_mode == MODE_SCROLL) && (pattern != r_prev_pattern)) begin
                w_shadow_nxt = pattern;
            end else if ((r_mode == MODE_SCROLL) && w_step) begin
                w_shadow_nxt = rotl1(r_shadow);
            end else begin
                w_shadow_nxt = r_shadow;
            end
        end
    end

    // LED word selected from the post-edge effect state so the pins track it with one cycle of latency.
    always_comb begin
        w_led_nxt = 16'h0000;
        case (w_mode_nxt)
            MODE_PASS:   w_led_nxt = pattern;
            MODE_BLINK:  w_led_nxt = w_phase_nxt ? pattern : 16'h0000;
            MODE_SCROLL: w_led_nxt = w_shadow_nxt;
            MODE_DIM:    w_led_nxt = (w_pwm_nxt < w_duty_nxt) ? pattern : 16'h0000;
            default:     w_led_nxt = 16'h0000;
        endcase
    end

    // Effect state and LED output registers.
    always_ff @(posedge ledclk or posedge ledrst) begin
        if (ledrst) begin
            r_mode         <= MODE_PASS;
            r_rate         <= 4'd0;
            r_duty         <= 4'd0;
            r_phase        <= 1'b0;
            r_pwm          <= 4'd0;
            r_shadow       <= 16'h0000;
            r_prev_pattern <= 16'h0000;
            r_led_pin      <= 16'h0000;
        end else begin
            r_mode         <= w_mode_nxt;
            r_rate         <= w_rate_nxt;
            r_duty         <= w_duty_nxt;
            r_phase        <= w_phase_nxt;
            r_pwm          <= w_pwm_nxt;
            r_shadow       <= w_shadow_nxt;
            r_prev_pattern <= pattern;
            r_led_pin      <= w_led_nxt;
        end
    end

endmodule

// File: tb/tb_led_effect_engine.sv
// Directed self-checking bench for led_effect_engine with TICK_DIV = 4.
module tb_led_effect_engine;

    logic        ledclk;
    logic        ledrst;
    logic [15:0] pattern;
    logic        cfgcs;
    logic        cfgwrite;
    logic [15:0] cfgdata;
    logic [15:0] led_pin;
    logic        step;

    int checks;
    int errors;
    int ons;
    int bad;

    led_effect_engine #(
        .TICK_DIV (4)
    ) dut (
        .ledclk   (ledclk),
        .ledrst   (ledrst),
        .pattern  (pattern),
        .cfgcs    (cfgcs),
        .cfgwrite (cfgwrite),
        .cfgdata  (cfgdata),
        .led_pin  (led_pin),
        .step     (step)
    );

    initial ledclk = 1'b0;
    always #5 ledclk = ~ledclk;

    task automatic edges(input int n);
        repeat (n) @(posedge ledclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-edge config write; returns 1 ns after the write edge.
    task automatic cfg_write(input logic [15:0] data);
        cfgcs    = 1'b1;
        cfgwrite = 1'b1;
        cfgdata  = data;
        edges(1);
        cfgcs    = 1'b0;
        cfgwrite = 1'b0;
        cfgdata  = 16'h0000;
    endtask

    task automatic dim_count(input logic [15:0] data, input int exp_on, input string tag);
        cfg_write(data);
        ons = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (led_pin === pattern) ons++;
            else if (led_pin !== 16'h0000) bad++;
            edges(1);
        end
        chk({tag, "_on"}, 16'(ons), 16'(exp_on));
        chk({tag, "_bad"}, 16'(bad), 16'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ledrst   = 1'b1;
        pattern  = 16'h0000;
        cfgcs    = 1'b0;
        cfgwrite = 1'b0;
        cfgdata  = 16'h0000;

        edges(2);
        chk("rst_led", led_pin, 16'h0000);
        chk("rst_step", {15'd0, step}, 16'd0);

        ledrst  = 1'b0;
        pattern = 16'hA5A5;
        chk("pass_no_comb", led_pin, 16'h0000);
        edges(1);
        chk("pass_first_edge", led_pin, 16'hA5A5);
        edges(2);
        chk("pass_step_before", {15'd0, step}, 16'd0);
        edges(1);
        chk("pass_step_rate0", {15'd0, step}, 16'd1);
        edges(1);
        chk("pass_step_one_cycle", {15'd0, step}, 16'd0);

        ledrst = 1'b1;
        #1;
        chk("midrst_led", led_pin, 16'h0000);
        chk("midrst_step", {15'd0, step}, 16'd0);
        edges(1);
        ledrst = 1'b0;
        edges(1);
        chk("after_midrst_pass", led_pin, 16'hA5A5);

        // cs without write and write without cs must not latch DIM/duty 0
        pattern  = 16'h00FF;
        cfgcs    = 1'b1;
        cfgdata  = 16'h0003;
        edges(1);
        cfgcs    = 1'b0;
        cfgwrite = 1'b1;
        edges(1);
        cfgwrite = 1'b0;
        cfgdata  = 16'h0000;
        chk("cfg_unqualified", led_pin, 16'h00FF);

        cfg_write(16'h0005);
        chk("blink_w0_led", led_pin, 16'h0000);
        chk("blink_w0_step", {15'd0, step}, 16'd0);
        edges(8);
        chk("blink_step8", {15'd0, step}, 16'd1);
        chk("blink_led8", led_pin, 16'h0000);
        edges(1);
        chk("blink_led9_on", led_pin, 16'h00FF);
        chk("blink_step9", {15'd0, step}, 16'd0);
        edges(7);
        chk("blink_step16", {15'd0, step}, 16'd1);
        chk("blink_led16", led_pin, 16'h00FF);
        edges(1);
        chk("blink_led17_off", led_pin, 16'h0000);

        pattern = 16'h8001;
        edges(1);
        cfg_write(16'h0002);
        chk("scroll_entry", led_pin, 16'h8001);
        edges(4);
        chk("scroll_step4", {15'd0, step}, 16'd1);
        chk("scroll_led4", led_pin, 16'h8001);
        edges(1);
        chk("scroll_rot1", led_pin, 16'h0003);
        edges(4);
        chk("scroll_rot2", led_pin, 16'h0006);

        edges(2);
        cfg_write(16'h0002);
        chk("tickwr_no_step", {15'd0, step}, 16'd0);
        chk("tickwr_reload", led_pin, 16'h8001);
        edges(3);
        chk("tickwr_step3", {15'd0, step}, 16'd0);
        edges(1);
        chk("tickwr_step4", {15'd0, step}, 16'd1);
        edges(1);
        chk("tickwr_rot", led_pin, 16'h0003);
        pattern = 16'h0010;
        edges(1);
        chk("scroll_pat_reload", led_pin, 16'h0010);
        edges(3);
        chk("scroll_rot_new", led_pin, 16'h0020);

        pattern = 16'h1234;
        edges(1);
        dim_count(16'h0103, 4, "dim4");
        dim_count(16'hFC03, 0, "dim0");
        dim_count(16'h03C3, 15, "dim15");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
